// File: rtl/stopwatch_ctrl.sv
// ============================================================================
// stopwatch_ctrl : stopwatch control FSM with MM:SS BCD counter and adjust blink
// Revision: 1.0
// ============================================================================
`default_nettype none

module stopwatch_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        tick_1hz,
   input  logic        tick_adj,
   input  logic        tick_blink,
   input  logic        btn_reset,
   input  logic        btn_pause,
   input  logic        adj,
   input  logic [1:0]  sel,
   input  logic [3:0]  num,
   output logic [15:0] digits,
   output logic [3:0]  blank,
   output logic        running,
   output logic [1:0]  state
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_PAUSE  = 2'd2,
      ST_ADJUST = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] digits_q, digits_d;
   logic [3:0]  blank_q, blank_d;
   logic        running_q, running_d;
   logic        phase_q, phase_d;
   logic        rst_prev_q, pause_prev_q;
   logic        rst_edge_q, pause_edge_q;

   function automatic logic [15:0] bcd_inc(input logic [15:0] d);
      logic [3:0] s0, s1, m0, m1;
      s0 = d[3:0];
      s1 = d[7:4];
      m0 = d[11:8];
      m1 = d[15:12];
      if (s0 != 4'd9) begin
         s0 = s0 + 4'd1;
      end else begin
         s0 = 4'd0;
         if (s1 != 4'd5) begin
            s1 = s1 + 4'd1;
         end else begin
            s1 = 4'd0;
            if (m0 != 4'd9) begin
               m0 = m0 + 4'd1;
            end else begin
               m0 = 4'd0;
               m1 = (m1 != 4'd9) ? m1 + 4'd1 : 4'd0;
            end
         end
      end
      return {m1, m0, s1, s0};
   endfunction

   function automatic logic [15:0] digit_load(input logic [15:0] d,
                                              input logic [1:0]  s,
                                              input logic [3:0]  n);
      logic [3:0]  v;
      logic [15:0] r;
      v = (n > 4'd9) ? 4'd9 : n;
      // Seconds tens only ever holds 0..5.
      if (s == 2'd1 && v > 4'd5) begin
         v = 4'd5;
      end
      r = d;
      case (s)
         2'd0:    r[3:0]   = v;
         2'd1:    r[7:4]   = v;
         2'd2:    r[11:8]  = v;
         default: r[15:12] = v;
      endcase
      return r;
   endfunction

   always_comb begin
      state_d  = state_q;
      digits_d = digits_q;
      if (rst_edge_q) begin
         digits_d = 16'h0000;
         state_d  = adj ? ST_ADJUST : ST_IDLE;
      end else if (adj && state_q != ST_ADJUST) begin
         state_d = ST_ADJUST;
      end else if (!adj && state_q == ST_ADJUST) begin
         state_d = ST_PAUSE;
      end else if (pause_edge_q && state_q != ST_ADJUST) begin
         state_d = (state_q == ST_RUN) ? ST_PAUSE : ST_RUN;
      end else if (tick_1hz && state_q == ST_RUN) begin
         digits_d = bcd_inc(digits_q);
      end else if (tick_adj && state_q == ST_ADJUST) begin
         digits_d = digit_load(digits_q, sel, num);
      end
   end

   // Blink phase only advances while adjusting, so entering ADJUST always starts visible.
   always_comb begin
      phase_d   = 1'b0;
      blank_d   = 4'b0000;
      running_d = (state_d == ST_RUN);
      if (state_d == ST_ADJUST) begin
         phase_d      = tick_blink ? ~phase_q : phase_q;
         blank_d[sel] = phase_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         digits_q     <= 16'h0000;
         blank_q      <= 4'b0000;
         running_q    <= 1'b0;
         phase_q      <= 1'b0;
         rst_prev_q   <= 1'b0;
         pause_prev_q <= 1'b0;
         rst_edge_q   <= 1'b0;
         pause_edge_q <= 1'b0;
      end else begin
         rst_prev_q   <= btn_reset;
         pause_prev_q <= btn_pause;
         rst_edge_q   <= btn_reset & ~rst_prev_q;
         pause_edge_q <= btn_pause & ~pause_prev_q;
         state_q      <= state_d;
         digits_q     <= digits_d;
         blank_q      <= blank_d;
         running_q    <= running_d;
         phase_q      <= phase_d;
      end
   end

   assign digits  = digits_q;
   assign blank   = blank_q;
   assign running = running_q;
   assign state   = state_q;

endmodule

`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
// ============================================================================
// tb_stopwatch_ctrl : directed self-checking bench for stopwatch_ctrl
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_stopwatch_ctrl;

   logic        clk;
   logic        rst_n;
   logic        tick_1hz, tick_adj, tick_blink;
   logic        btn_reset, btn_pause, adj;
   logic [1:0]  sel;
   logic [3:0]  num;
   logic [15:0] digits;
   logic [3:0]  blank;
   logic        running;
   logic [1:0]  state;

   int n_checks = 0;
   int n_errors = 0;

   localparam logic [1:0] C_IDLE   = 2'd0;
   localparam logic [1:0] C_RUN    = 2'd1;
   localparam logic [1:0] C_PAUSE  = 2'd2;
   localparam logic [1:0] C_ADJUST = 2'd3;

   stopwatch_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .tick_1hz   (tick_1hz),
      .tick_adj   (tick_adj),
      .tick_blink (tick_blink),
      .btn_reset  (btn_reset),
      .btn_pause  (btn_pause),
      .adj        (adj),
      .sel        (sel),
      .num        (num),
      .digits     (digits),
      .blank      (blank),
      .running    (running),
      .state      (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic tick_sec(input int n);
      for (int i = 0; i < n; i++) begin
         tick_1hz = 1'b1;
         cyc();
         tick_1hz = 1'b0;
         cyc();
      end
   endtask

   task automatic press_pause(input logic with_tick);
      btn_pause = 1'b1;
      cyc();
      tick_1hz = with_tick;
      cyc();
      tick_1hz  = 1'b0;
      btn_pause = 1'b0;
      cyc();
   endtask

   task automatic load(input logic [1:0] s, input logic [3:0] n);
      sel      = s;
      num      = n;
      tick_adj = 1'b1;
      cyc();
      tick_adj = 1'b0;
   endtask

   task automatic blink();
      tick_blink = 1'b1;
      cyc();
      tick_blink = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      tick_1hz = 0; tick_adj = 0; tick_blink = 0;
      btn_reset = 0; btn_pause = 0; adj = 0;
      sel = 2'd0; num = 4'd0;
      #22;
      check("rst_digits",  digits,  16'h0000);
      check("rst_state",   {14'd0, state}, {14'd0, C_IDLE});
      check("rst_running", {15'd0, running}, 16'd0);
      check("rst_blank",   {12'd0, blank}, 16'd0);
      rst_n = 1'b1;
      cyc();

      // Count and carry
      press_pause(1'b0);
      check("run_state", {14'd0, state}, {14'd0, C_RUN});
      tick_sec(70);
      check("count70", digits, 16'h0110);
      check("count70_run", {15'd0, running}, 16'd1);
      check("count70_state", {14'd0, state}, {14'd0, C_RUN});

      // Wrap at 99:59
      adj = 1'b1;
      cyc();
      check("adj_state", {14'd0, state}, {14'd0, C_ADJUST});
      check("adj_running", {15'd0, running}, 16'd0);
      load(2'd3, 4'd9);
      load(2'd2, 4'd9);
      load(2'd1, 4'd9);
      load(2'd0, 4'd9);
      check("load9959", digits, 16'h9959);
      adj = 1'b0;
      cyc();
      check("adj_exit_pause", {14'd0, state}, {14'd0, C_PAUSE});
      press_pause(1'b0);
      tick_sec(1);
      check("wrap_digits", digits, 16'h0000);
      check("wrap_state", {14'd0, state}, {14'd0, C_RUN});

      // Pause/hold
      tick_sec(5);
      check("at0005", digits, 16'h0005);
      press_pause(1'b0);
      tick_sec(10);
      check("hold_digits", digits, 16'h0005);
      check("hold_state", {14'd0, state}, {14'd0, C_PAUSE});
      press_pause(1'b1);
      check("resume_tick_digits", digits, 16'h0005);
      check("resume_tick_state", {14'd0, state}, {14'd0, C_RUN});
      tick_sec(1);
      check("resume_inc", digits, 16'h0006);
      press_pause(1'b1);
      check("pause_tick_digits", digits, 16'h0006);
      check("pause_tick_state", {14'd0, state}, {14'd0, C_PAUSE});

      // Adjust clamp and blink
      adj = 1'b1;
      cyc();
      check("adj2_blank0", {12'd0, blank}, 16'd0);
      load(2'd1, 4'd9);
      check("clamp_sec_tens", digits, 16'h0056);
      load(2'd0, 4'd12);
      check("clamp_gt9", digits, 16'h0059);
      sel = 2'd1;
      blink();
      check("blink_on", {12'd0, blank}, 16'h0002);
      blink();
      check("blink_off", {12'd0, blank}, 16'h0000);
      blink();
      sel = 2'd3;
      cyc();
      check("blink_sel3", {12'd0, blank}, 16'h0008);
      adj = 1'b0;
      cyc();
      check("adj2_exit_state", {14'd0, state}, {14'd0, C_PAUSE});
      check("adj2_exit_blank", {12'd0, blank}, 16'd0);
      check("adj2_exit_digits", digits, 16'h0059);

      // Priority: reset edge beats pause edge and tick
      press_pause(1'b0);
      check("prio_pre_run", {14'd0, state}, {14'd0, C_RUN});
      btn_reset = 1'b1; btn_pause = 1'b1;
      cyc();
      tick_1hz = 1'b1;
      cyc();
      tick_1hz = 1'b0; btn_reset = 1'b0; btn_pause = 1'b0;
      check("prio_digits", digits, 16'h0000);
      check("prio_state", {14'd0, state}, {14'd0, C_IDLE});
      cyc();
      press_pause(1'b0);
      tick_sec(3);
      check("prio2_pre", digits, 16'h0003);
      btn_reset = 1'b1; btn_pause = 1'b1;
      cyc();
      tick_1hz = 1'b1; adj = 1'b1;
      cyc();
      tick_1hz = 1'b0; btn_reset = 1'b0; btn_pause = 1'b0;
      check("prio2_digits", digits, 16'h0000);
      check("prio2_state", {14'd0, state}, {14'd0, C_ADJUST});

      // Async reset at 12:34 in RUN
      load(2'd3, 4'd1);
      load(2'd2, 4'd2);
      load(2'd1, 4'd3);
      load(2'd0, 4'd4);
      adj = 1'b0;
      cyc();
      press_pause(1'b0);
      check("pre_async_digits", digits, 16'h1234);
      check("pre_async_state", {14'd0, state}, {14'd0, C_RUN});
      #2;
      rst_n = 1'b0;
      #1;
      check("async_digits", digits, 16'h0000);
      check("async_state", {14'd0, state}, {14'd0, C_IDLE});
      check("async_running", {15'd0, running}, 16'd0);
      check("async_blank", {12'd0, blank}, 16'd0);
      btn_pause = 1'b1;
      cyc();
      cyc();
      #3;
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) cyc();
      check("held_btn_state", {14'd0, state}, {14'd0, C_RUN});
      check("held_btn_running", {15'd0, running}, 16'd1);
      btn_pause = 1'b0;
      cyc();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
